// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   In-order issue queue feeding an external combinational 4-bit ALU.
//   Ops enter through a valid/ready port and wait in a FIFO of DEPTH entries.
//   The head entry drives the ALU. The ALU result is captured into a
//   writeback register that has a valid/ready handshake.
//   Legal opcodes are 4'b0000 (add) and 4'b1111 (mul). Any other opcode
//   issues normally but writes back result 0 with wb_err set.
//
// Optional feature:
//   ALU_ISSUE_BYPASS_EN - when the queue is empty and writeback can accept,
//                         the incoming op drives the ALU directly and is
//                         written back the same cycle, skipping the FIFO.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            upstream op handshake
//   in_op, in_a, in_b, in_tag    op payload
//   alu_a, alu_b, alu_ctrl       operands and control to the combinational ALU
//   alu_result                   combinational ALU result
//   flush                        synchronous discard of all in-flight ops
//   wb_valid/wb_ready            writeback handshake
//   wb_result, wb_tag, wb_err    writeback payload
//   count                        queue occupancy (excludes the writeback register)
module alu_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic [3:0]                 in_a,
    input  logic [3:0]                 in_b,
    input  logic [TAG_W-1:0]           in_tag,
    output logic [3:0]                 alu_a,
    output logic [3:0]                 alu_b,
    output logic [3:0]                 alu_ctrl,
    input  logic [3:0]                 alu_result,
    input  logic                       flush,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [3:0]                 wb_result,
    output logic [TAG_W-1:0]           wb_tag,
    output logic                       wb_err,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [3:0]  OP_ADD = 4'b0000;
    localparam logic [3:0]  OP_MUL = 4'b1111;

    typedef struct packed {
        logic [3:0]       op;
        logic [3:0]       a;
        logic [3:0]       b;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // Payload storage carries no reset; occupancy is tracked by count.
    entry_t         mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    entry_t           head;
    entry_t           in_entry;
    logic             head_valid;
    logic             can_issue;
    logic             bypass;
    logic             issue_q;
    logic             issue;
    logic             enq;
    logic [3:0]       issue_op;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_legal;

    logic [PW-1:0]    wr_ptr_next;
    logic [PW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_next;
    logic             in_ready_next;
    logic             wb_valid_next;
    logic [3:0]       wb_result_next;
    logic [TAG_W-1:0] wb_tag_next;
    logic             wb_err_next;

    // Issue decision, ALU drive and next-state computation.
    always_comb begin
        head        = mem[rd_ptr];
        in_entry    = '{op: in_op, a: in_a, b: in_b, tag: in_tag};
        head_valid  = (count != '0);
        can_issue   = !wb_valid || wb_ready;

`ifdef ALU_ISSUE_BYPASS_EN
        bypass = !head_valid && in_valid && can_issue;
`else
        bypass = 1'b0;
`endif

        issue_q = head_valid && can_issue;
        issue   = issue_q || bypass;
        enq     = in_valid && in_ready && !bypass;

        // ALU sees the head entry, the bypassed input, or zeros when idle.
        alu_a    = 4'b0000;
        alu_b    = 4'b0000;
        alu_ctrl = 4'b0000;
        if (head_valid) begin
            alu_a    = head.a;
            alu_b    = head.b;
            alu_ctrl = head.op;
        end
`ifdef ALU_ISSUE_BYPASS_EN
        else if (bypass) begin
            alu_a    = in_a;
            alu_b    = in_b;
            alu_ctrl = in_op;
        end
`endif

        issue_op    = bypass ? in_op  : head.op;
        issue_tag   = bypass ? in_tag : head.tag;
        issue_legal = (issue_op == OP_ADD) || (issue_op == OP_MUL);

        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (enq)     wr_ptr_next = wr_ptr + PW'(1);
            if (issue_q) rd_ptr_next = rd_ptr + PW'(1);
            count_next = count + CW'(enq) - CW'(issue_q);
        end
        in_ready_next = (count_next < CW'(DEPTH));

        wb_valid_next  = wb_valid;
        wb_result_next = wb_result;
        wb_tag_next    = wb_tag;
        wb_err_next    = wb_err;
        if (flush) begin
            wb_valid_next  = 1'b0;
            wb_result_next = 4'b0000;
            wb_tag_next    = '0;
            wb_err_next    = 1'b0;
        end else if (issue) begin
            wb_valid_next  = 1'b1;
            wb_result_next = issue_legal ? alu_result : 4'b0000;
            wb_tag_next    = issue_tag;
            wb_err_next    = !issue_legal;
        end else if (wb_valid && wb_ready) begin
            wb_valid_next  = 1'b0;
        end
    end

    // Control and writeback state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            wb_valid  <= 1'b0;
            wb_result <= 4'b0000;
            wb_tag    <= '0;
            wb_err    <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            in_ready  <= in_ready_next;
            wb_valid  <= wb_valid_next;
            wb_result <= wb_result_next;
            wb_tag    <= wb_tag_next;
            wb_err    <= wb_err_next;
        end
    end

    // Payload write; an op arriving together with flush is dropped.
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            mem[wr_ptr] <= in_entry;
        end
    end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 3, destination-tag width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream op valid.
REQ-006 SHALL have port in_ready  output  1  queue can accept.
REQ-007 SHALL have port in_op  input  4  ALU control code.
REQ-008 SHALL have ports in_a, in_b  input  4 each  signed operands.
REQ-009 SHALL have port in_tag  input  TAG_W  destination tag.
REQ-010 SHALL have ports alu_a, alu_b, alu_ctrl  output  4 each  drive the combinational ALU.
REQ-011 SHALL have port alu_result  input  4  combinational ALU result.
REQ-012 SHALL have port flush  input  1  synchronous discard of all in-flight ops.
REQ-013 SHALL have ports wb_valid output 1, wb_ready input 1, wb_result output 4, wb_tag output TAG_W, wb_err output 1  writeback handshake.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-015 Enqueue SHALL occur when in_valid && in_ready; in_ready = (count < DEPTH), no pass-through when full.
REQ-016 Queue SHALL be FIFO with wrapping read/write pointers; simultaneous enqueue and issue SHALL leave count unchanged.
REQ-017 Head entry SHALL drive alu_a/alu_b/alu_ctrl; when queue empty (and no bypass) SHALL drive 0/0/4'b0000.
REQ-018 Issue SHALL occur when head valid and (!wb_valid || wb_ready); on issue head pops and wb register loads alu_result, head tag, wb_valid=1.
REQ-019 wb register SHALL hold value while wb_valid && !wb_ready; wb_valid clears on handshake with no issue in the same cycle.
REQ-020 Legal opcodes SHALL be 4'b0000 (add) and 4'b1111 (mul); other opcodes SHALL issue normally but load wb_result=0, wb_err=1.
REQ-021 Result SHALL be the 4-bit ALU value (two's-complement wrap, multiply truncated to low 4 bits); no saturation.
REQ-022 Latency without bypass SHALL be: accepted cycle N -> wb_valid in cycle N+2 when unstalled; throughput one op per cycle.
REQ-023 flush SHALL empty queue, clear wb_valid and wb_err next cycle, and take priority over simultaneous enqueue and issue.
REQ-024 in_ready SHALL not depend combinationally on wb_ready.

Reset
REQ-025 On rst_n low, SHALL asynchronously clear pointers, count=0, wb_valid=0, wb_result=0, wb_tag=0, wb_err=0; in_ready=1 during/after reset.
REQ-026 Reset mid-operation SHALL discard all queued and writeback ops; no output pulse on release.
REQ-027 Queue payload storage need not be reset.

Configuration
REQ-028 Macro ALU_ISSUE_BYPASS_EN SHALL select empty-queue bypass.
REQ-029 With ALU_ISSUE_BYPASS_EN defined: when queue empty, in_valid high and issue allowed, input SHALL drive ALU directly and load wb register the same cycle (wb_valid at N+1), not entering the queue.
REQ-030 Without the macro: every op SHALL pass through the queue; latency per REQ-022; alu_* depend only on registered state.

Verification
REQ-031 add: op 0000, a=3, b=2, tag=1, wb_ready=1 -> wb_valid at N+2 (N+1 with bypass), wb_result=5, wb_tag=1, wb_err=0.
REQ-032 wrap/truncate: add 7+1 -> wb_result 4'b1000; mul 4*5 -> 4'b0100; mul -2*3 -> 4'b1010.
REQ-033 backpressure: wb_ready=0, push 6 ops -> 5 accepted (1 in wb, count=4), in_ready=0; release wb_ready -> results drain in order, one per cycle.
REQ-034 illegal op 0101, a=1, b=1 -> wb_err=1, wb_result=0, queue advances.
REQ-035 flush with count=3 and simultaneous in_valid -> next cycle count=0, wb_valid=0, new op dropped; rst_n pulse mid-stream -> same empty state asynchronously.
